// File: rtl/vga_sprite_pkg.sv
// Shared types and default sizes for the VGA sprite attribute controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package vga_sprite_pkg;

  localparam int DEF_LAYERS  = 64;
  localparam int DEF_COORD_W = 10;
  localparam int DEF_SIZE_W  = 6;

  // Host address low two bits select the attribute field of a layer
  typedef enum logic [1:0] {
    FLD_X    = 2'd0,
    FLD_Y    = 2'd1,
    FLD_SIZE = 2'd2,
    FLD_CTRL = 2'd3
  } field_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SCAN    = 2'd1,
    ST_PUBLISH = 2'd2
  } scan_state_t;

  // One layer's attributes; widths follow the package defaults
  typedef struct packed {
    logic                   en;
    logic [DEF_COORD_W-1:0] x;
    logic [DEF_COORD_W-1:0] y;
    logic [DEF_SIZE_W-1:0]  w;
    logic [DEF_SIZE_W-1:0]  h;
  } sprite_attr_t;

endpackage

// File: rtl/vga_sprite_hit.sv
// Vertical hit test and row offset for one sprite against one scanline.
// Latency: combinational.
// Backpressure: none.
module vga_sprite_hit
  import vga_sprite_pkg::*;
#(
  parameter int COORD_W = DEF_COORD_W,
  parameter int SIZE_W  = DEF_SIZE_W
) (
  input  sprite_attr_t        attr,
  input  logic [COORD_W-1:0]  line_y,
  output logic                hit,
  output logic [SIZE_W-1:0]   row
);

  // One extra bit so a line above the sprite shows up as a borrow instead of wrapping
  logic [COORD_W:0] diff;
  logic             unused_attr;

  assign diff        = {1'b0, line_y} - {1'b0, attr.y};
  // H=0 can never satisfy diff < H, so empty sprites need no special case
  assign hit         = attr.en && !diff[COORD_W] && (diff < (COORD_W+1)'(attr.h));
  assign row         = diff[SIZE_W-1:0];
  assign unused_attr = ^{attr.x, attr.w};

endmodule

// File: rtl/vga_sprite_ctrl.sv
// Double-buffered sprite attribute tables plus per-scanline hit scheduler (VGA_SPRITE_READBACK_EN enables shadow readback).
// Latency: host write lands same cycle; line outputs update LAYERS+1 cycles after LINE_START; commit one cycle after arming.
// Backpressure: none; host writes always accepted, LINE_START restarts any scan in progress.
module vga_sprite_ctrl
  import vga_sprite_pkg::*;
#(
  parameter int LAYERS  = DEF_LAYERS,
  parameter int COORD_W = DEF_COORD_W,
  parameter int SIZE_W  = DEF_SIZE_W,
  localparam int LW     = $clog2(LAYERS),
  localparam int AW     = LW + 2
) (
  input  logic                        Clk,
  input  logic                        Reset,
  input  logic                        HOST_WE,
  input  logic [AW-1:0]               HOST_ADDR,
  input  logic [15:0]                 HOST_WDATA,
  output logic [15:0]                 HOST_RDATA,
  input  logic                        HOST_COMMIT,
  output logic                        COMMIT_PENDING,
  output logic                        COMMIT_DONE,
  input  logic                        FRAME_START,
  input  logic                        LINE_START,
  input  logic [COORD_W-1:0]          LINE_Y,
  output logic [LAYERS-1:0]           SPRITE_LINE_EN,
  output logic [LAYERS*SIZE_W-1:0]    SPRITE_ROW,
  output logic [LAYERS*COORD_W-1:0]   SPRITE_X,
  output logic                        SCAN_BUSY
);

  sprite_attr_t shadow_q [LAYERS];
  sprite_attr_t shadow_d [LAYERS];
  sprite_attr_t active_q [LAYERS];
  sprite_attr_t active_d [LAYERS];

  logic pending_q, pending_d;
  logic armed_q, armed_d;
  logic done_q, done_d;
  logic commit_fire;

  scan_state_t                        state_q, state_d;
  logic [LW-1:0]                      idx_q, idx_d;
  logic [COORD_W-1:0]                 line_y_q, line_y_d;
  logic [LAYERS-1:0]                  stage_en_q, stage_en_d;
  logic [LAYERS-1:0][SIZE_W-1:0]      stage_row_q, stage_row_d;
  logic [LAYERS-1:0]                  line_en_q, line_en_d;
  logic [LAYERS-1:0][SIZE_W-1:0]      row_out_q, row_out_d;
  logic [LAYERS-1:0][COORD_W-1:0]     x_out_q, x_out_d;

  logic [LW-1:0]       wr_layer;
  field_e              wr_field;
  logic                cur_hit;
  logic [SIZE_W-1:0]   cur_row;
  logic                unused_wdata;

  assign wr_layer     = HOST_ADDR[AW-1:2];
  assign wr_field     = field_e'(HOST_ADDR[1:0]);
  assign unused_wdata = ^HOST_WDATA[15:14];

  // Commit only between scans so a line never sees a half-swapped table
  assign commit_fire = pending_q && armed_q && (state_q == ST_IDLE);

  // Host writes into the shadow table; unused data bits are dropped
  always_comb begin
    shadow_d = shadow_q;
    if (HOST_WE) begin
      case (wr_field)
        FLD_X:    shadow_d[wr_layer].x  = HOST_WDATA[COORD_W-1:0];
        FLD_Y:    shadow_d[wr_layer].y  = HOST_WDATA[COORD_W-1:0];
        FLD_SIZE: begin
          shadow_d[wr_layer].h = HOST_WDATA[8+SIZE_W-1:8];
          shadow_d[wr_layer].w = HOST_WDATA[SIZE_W-1:0];
        end
        default:  shadow_d[wr_layer].en = HOST_WDATA[0];
      endcase
    end
  end

  // Commit handshake: copy uses the pre-write shadow, so a same-cycle write waits for the next commit
  always_comb begin
    active_d  = active_q;
    pending_d = pending_q || HOST_COMMIT;
    armed_d   = armed_q;
    done_d    = commit_fire;
    if (commit_fire) begin
      active_d  = shadow_q;
      pending_d = HOST_COMMIT;
      armed_d   = 1'b0;
    end
    if (FRAME_START) armed_d = 1'b1;
    if (LINE_START)  armed_d = 1'b0;
  end

  // Single comparator shared by all layers, one layer per scan cycle
  vga_sprite_hit #(
    .COORD_W (COORD_W),
    .SIZE_W  (SIZE_W)
  ) u_hit (
    .attr    (active_q[idx_q]),
    .line_y  (line_y_q),
    .hit     (cur_hit),
    .row     (cur_row)
  );

  // Scan FSM next-state and staging/output updates
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    line_y_d    = line_y_q;
    stage_en_d  = stage_en_q;
    stage_row_d = stage_row_q;
    line_en_d   = line_en_q;
    row_out_d   = row_out_q;
    x_out_d     = x_out_q;
    case (state_q)
      ST_SCAN: begin
        stage_en_d[idx_q]  = cur_hit;
        stage_row_d[idx_q] = cur_row;
        idx_d              = idx_q + 1'b1;
        if (idx_q == LW'(LAYERS-1)) state_d = ST_PUBLISH;
      end
      ST_PUBLISH: begin
        line_en_d = stage_en_q;
        row_out_d = stage_row_q;
        for (int i = 0; i < LAYERS; i++) x_out_d[i] = active_q[i].x;
        state_d   = ST_IDLE;
      end
      default: ;
    endcase
    // A new line always wins and leaves the published outputs untouched
    if (LINE_START) begin
      line_y_d   = LINE_Y;
      stage_en_d = '0;
      idx_d      = '0;
      state_d    = ST_SCAN;
      line_en_d  = line_en_q;
      row_out_d  = row_out_q;
      x_out_d    = x_out_q;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge Clk) begin
    if (Reset) begin
      shadow_q    <= '{default: '0};
      active_q    <= '{default: '0};
      pending_q   <= 1'b0;
      armed_q     <= 1'b0;
      done_q      <= 1'b0;
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      line_y_q    <= '0;
      stage_en_q  <= '0;
      stage_row_q <= '0;
      line_en_q   <= '0;
      row_out_q   <= '0;
      x_out_q     <= '0;
    end else begin
      shadow_q    <= shadow_d;
      active_q    <= active_d;
      pending_q   <= pending_d;
      armed_q     <= armed_d;
      done_q      <= done_d;
      state_q     <= state_d;
      idx_q       <= idx_d;
      line_y_q    <= line_y_d;
      stage_en_q  <= stage_en_d;
      stage_row_q <= stage_row_d;
      line_en_q   <= line_en_d;
      row_out_q   <= row_out_d;
      x_out_q     <= x_out_d;
    end
  end

`ifdef VGA_SPRITE_READBACK_EN
  logic [15:0] rdata_q, rdata_d;

  // Registered readback of the addressed shadow field, zero-extended
  always_comb begin
    rdata_d = '0;
    case (wr_field)
      FLD_X:    rdata_d[COORD_W-1:0] = shadow_q[wr_layer].x;
      FLD_Y:    rdata_d[COORD_W-1:0] = shadow_q[wr_layer].y;
      FLD_SIZE: begin
        rdata_d[8+SIZE_W-1:8] = shadow_q[wr_layer].h;
        rdata_d[SIZE_W-1:0]   = shadow_q[wr_layer].w;
      end
      default:  rdata_d[0] = shadow_q[wr_layer].en;
    endcase
  end

  // Readback register
  always_ff @(posedge Clk) begin
    if (Reset) rdata_q <= '0;
    else       rdata_q <= rdata_d;
  end

  assign HOST_RDATA = rdata_q;
`else
  assign HOST_RDATA = '0;
`endif

  assign COMMIT_PENDING = pending_q;
  assign COMMIT_DONE    = done_q;
  assign SCAN_BUSY      = (state_q != ST_IDLE);
  assign SPRITE_LINE_EN = line_en_q;
  assign SPRITE_ROW     = row_out_q;
  assign SPRITE_X       = x_out_q;

endmodule

// File: tb/tb_vga_sprite_ctrl.sv
// Directed bench for vga_sprite_ctrl: vector table of scanlines plus commit/abort/reset sequences.
// Latency: checks outputs 65 cycles after each LINE_START.
// Backpressure: none.
module tb_vga_sprite_ctrl;

  logic         Clk = 1'b0;
  logic         Reset;
  logic         HOST_WE;
  logic [7:0]   HOST_ADDR;
  logic [15:0]  HOST_WDATA;
  logic [15:0]  HOST_RDATA;
  logic         HOST_COMMIT;
  logic         COMMIT_PENDING;
  logic         COMMIT_DONE;
  logic         FRAME_START;
  logic         LINE_START;
  logic [9:0]   LINE_Y;
  logic [63:0]  SPRITE_LINE_EN;
  logic [383:0] SPRITE_ROW;
  logic [639:0] SPRITE_X;
  logic         SCAN_BUSY;

  int checks = 0;
  int errors = 0;

  vga_sprite_ctrl dut (
    .Clk            (Clk),
    .Reset          (Reset),
    .HOST_WE        (HOST_WE),
    .HOST_ADDR      (HOST_ADDR),
    .HOST_WDATA     (HOST_WDATA),
    .HOST_RDATA     (HOST_RDATA),
    .HOST_COMMIT    (HOST_COMMIT),
    .COMMIT_PENDING (COMMIT_PENDING),
    .COMMIT_DONE    (COMMIT_DONE),
    .FRAME_START    (FRAME_START),
    .LINE_START     (LINE_START),
    .LINE_Y         (LINE_Y),
    .SPRITE_LINE_EN (SPRITE_LINE_EN),
    .SPRITE_ROW     (SPRITE_ROW),
    .SPRITE_X       (SPRITE_X),
    .SCAN_BUSY      (SCAN_BUSY)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [9:0]  line_y;
    logic [63:0] mask;
    int          lay;
    logic [5:0]  row;
    logic [9:0]  x;
  } vec_t;

  vec_t vecs [8];

  localparam logic [63:0] B3  = 64'h0000_0000_0000_0008;
  localparam logic [63:0] B10 = 64'h0000_0000_0000_0400;
  localparam logic [63:0] B63 = 64'h8000_0000_0000_0000;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic host_wr(input int layer, input int field, input logic [15:0] data);
    HOST_WE    = 1'b1;
    HOST_ADDR  = 8'((layer << 2) | field);
    HOST_WDATA = data;
    tick();
    HOST_WE    = 1'b0;
  endtask

  task automatic sprite(input int layer, input int x, input int y, input int h, input int en);
    host_wr(layer, 0, 16'(x));
    host_wr(layer, 1, 16'(y));
    host_wr(layer, 2, 16'((h << 8) | 8));
    host_wr(layer, 3, 16'(en));
  endtask

  // Drives LINE_START through cycle 0
  task automatic start_line(input logic [9:0] y);
    LINE_START = 1'b1;
    LINE_Y     = y;
    tick();
    LINE_START = 1'b0;
  endtask

  task automatic run_line(input logic [9:0] y);
    start_line(y);
    repeat (65) tick();
  endtask

  task automatic pulse_frame();
    FRAME_START = 1'b1;
    tick();
    FRAME_START = 1'b0;
  endtask

  task automatic pulse_commit();
    HOST_COMMIT = 1'b1;
    tick();
    HOST_COMMIT = 1'b0;
  endtask

  initial begin
    vecs[0] = '{10'd55,   B3 | B63, 3,  6'd5,  10'd100};
    vecs[1] = '{10'd66,   64'h0,    3,  6'd0,  10'd100};
    vecs[2] = '{10'd49,   B63,      63, 6'd49, 10'd640};
    vecs[3] = '{10'd3,    B63,      10, 6'd0,  10'd500};
    vecs[4] = '{10'd0,    B63,      20, 6'd0,  10'd7};
    vecs[5] = '{10'd1023, B10,      10, 6'd3,  10'd500};
    vecs[6] = '{10'd65,   B3,       3,  6'd15, 10'd100};
    vecs[7] = '{10'd62,   B3 | B63, 63, 6'd62, 10'd640};

    Reset = 1'b1; HOST_WE = 1'b0; HOST_ADDR = '0; HOST_WDATA = '0;
    HOST_COMMIT = 1'b0; FRAME_START = 1'b0; LINE_START = 1'b0; LINE_Y = '0;
    repeat (3) tick();
    Reset = 1'b0;
    tick();

    chk("rst_line_en", SPRITE_LINE_EN, 64'h0);
    chk("rst_row",     64'(|SPRITE_ROW), 64'h0);
    chk("rst_x",       64'(|SPRITE_X), 64'h0);
    chk("rst_rdata",   64'(HOST_RDATA), 64'h0);
    chk("rst_pending", 64'(COMMIT_PENDING), 64'h0);
    chk("rst_done",    64'(COMMIT_DONE), 64'h0);
    chk("rst_busy",    64'(SCAN_BUSY), 64'h0);

    // Shadow only: nothing visible until committed
    sprite(3, 100, 50, 16, 1);
    start_line(10'd55);
    chk("busy_in_scan", 64'(SCAN_BUSY), 64'h1);
    repeat (65) tick();
    chk("nocommit_mask", SPRITE_LINE_EN, 64'h0);
    chk("idle_after",    64'(SCAN_BUSY), 64'h0);

    sprite(5,  200, 50,   16, 0);
    sprite(10, 500, 1020, 16, 1);
    sprite(20, 7,   0,    0,  1);
    sprite(63, 640, 0,    63, 1);

    // Commit with a host write landing in the commit cycle
    pulse_commit();
    chk("pend_rise", 64'(COMMIT_PENDING), 64'h1);
    pulse_frame();
    chk("no_early_pend", 64'(COMMIT_PENDING), 64'h1);
    chk("no_early_done", 64'(COMMIT_DONE), 64'h0);
    host_wr(3, 0, 16'd999);
    chk("commit_pend_clr", 64'(COMMIT_PENDING), 64'h0);
    chk("commit_done",     64'(COMMIT_DONE), 64'h1);
    tick();
    chk("commit_done_once", 64'(COMMIT_DONE), 64'h0);
    chk("commit_pend_stay", 64'(COMMIT_PENDING), 64'h0);

    for (int i = 0; i < 8; i++) begin
      run_line(vecs[i].line_y);
      chk($sformatf("vec%0d_mask", i), SPRITE_LINE_EN, vecs[i].mask);
      chk($sformatf("vec%0d_x", i), 64'(SPRITE_X[vecs[i].lay*10 +: 10]), 64'(vecs[i].x));
      if (vecs[i].mask[vecs[i].lay])
        chk($sformatf("vec%0d_row", i), 64'(SPRITE_ROW[vecs[i].lay*6 +: 6]), 64'(vecs[i].row));
    end

    HOST_ADDR = 8'((3 << 2) | 0);
    tick();
`ifdef VGA_SPRITE_READBACK_EN
    chk("readback_x3", 64'(HOST_RDATA), 64'd999);
`else
    chk("readback_tied", 64'(HOST_RDATA), 64'h0);
`endif

    // Abort: restart at cycle 30 with a new line, old outputs must hold
    start_line(10'd66);
    repeat (29) tick();
    start_line(10'd1023);
    repeat (34) tick();
    chk("abort_hold1", SPRITE_LINE_EN, B3 | B63);
    repeat (30) tick();
    chk("abort_hold2", SPRITE_LINE_EN, B3 | B63);
    tick();
    chk("abort_new", SPRITE_LINE_EN, B10);
    chk("abort_row", 64'(SPRITE_ROW[10*6 +: 6]), 64'd3);

    // FRAME_START mid-scan: commit waits for the scan to finish
    pulse_commit();
    start_line(10'd55);
    repeat (10) tick();
    pulse_frame();
    repeat (54) tick();
    chk("midscan_pend", 64'(COMMIT_PENDING), 64'h1);
    chk("midscan_idle", 64'(SCAN_BUSY), 64'h0);
    tick();
    chk("midscan_commit_pend", 64'(COMMIT_PENDING), 64'h0);
    chk("midscan_commit_done", 64'(COMMIT_DONE), 64'h1);
    run_line(10'd55);
    chk("midscan_x3", 64'(SPRITE_X[3*10 +: 10]), 64'd999);

    // LINE_START after FRAME_START disarms: commit deferred to next frame
    host_wr(3, 0, 16'd300);
    pulse_commit();
    start_line(10'd55);
    repeat (5) tick();
    pulse_frame();
    repeat (5) tick();
    start_line(10'd55);
    repeat (70) tick();
    chk("defer_pend", 64'(COMMIT_PENDING), 64'h1);
    chk("defer_x3",   64'(SPRITE_X[3*10 +: 10]), 64'd999);
    pulse_frame();
    tick();
    chk("defer_done", 64'(COMMIT_DONE), 64'h1);
    run_line(10'd55);
    chk("defer_x3_new", 64'(SPRITE_X[3*10 +: 10]), 64'd300);

    // FRAME_START and LINE_START together leave armed cleared
    pulse_commit();
    FRAME_START = 1'b1;
    start_line(10'd55);
    FRAME_START = 1'b0;
    repeat (70) tick();
    chk("same_cycle_pend", 64'(COMMIT_PENDING), 64'h1);

    // Reset mid-scan drops staging and tables
    start_line(10'd55);
    repeat (20) tick();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    chk("midrst_mask", SPRITE_LINE_EN, 64'h0);
    chk("midrst_busy", 64'(SCAN_BUSY), 64'h0);
    chk("midrst_pend", 64'(COMMIT_PENDING), 64'h0);
    repeat (70) tick();
    chk("midrst_nopub", SPRITE_LINE_EN, 64'h0);
    run_line(10'd55);
    chk("midrst_table", SPRITE_LINE_EN, 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
